// File: rtl/apb4_arbiter_if.sv
// Bus bundle for apb4_arbiter: flattened requester-side APB4 ports plus
// the shared downstream APB4 master port.
interface apb4_arbiter_if #(
    parameter int NUM_MASTERS    = 2,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
);
    localparam int SW = APB_DATA_WIDTH / 8;

    logic [NUM_MASTERS*APB_ADDR_WIDTH-1:0] s_paddr;
    logic [NUM_MASTERS*3-1:0]              s_pprot;
    logic [NUM_MASTERS-1:0]                s_psel;
    logic [NUM_MASTERS-1:0]                s_penable;
    logic [NUM_MASTERS-1:0]                s_pwrite;
    logic [NUM_MASTERS*APB_DATA_WIDTH-1:0] s_pwdata;
    logic [NUM_MASTERS*SW-1:0]             s_pstrb;
    logic [NUM_MASTERS-1:0]                s_pready;
    logic [APB_DATA_WIDTH-1:0]             s_prdata;
    logic [NUM_MASTERS-1:0]                s_pslverr;

    logic [APB_ADDR_WIDTH-1:0]             m_paddr;
    logic [2:0]                            m_pprot;
    logic                                  m_psel;
    logic                                  m_penable;
    logic                                  m_pwrite;
    logic [APB_DATA_WIDTH-1:0]             m_pwdata;
    logic [SW-1:0]                         m_pstrb;
    logic                                  m_pready;
    logic [APB_DATA_WIDTH-1:0]             m_prdata;
    logic                                  m_pslverr;

    // arbiter view: slave to the requesters, master to the shared segment
    modport slave (
        input  s_paddr, s_pprot, s_psel, s_penable, s_pwrite, s_pwdata, s_pstrb,
        output s_pready, s_prdata, s_pslverr,
        output m_paddr, m_pprot, m_psel, m_penable, m_pwrite, m_pwdata, m_pstrb,
        input  m_pready, m_prdata, m_pslverr
    );

    modport master (
        output s_paddr, s_pprot, s_psel, s_penable, s_pwrite, s_pwdata, s_pstrb,
        input  s_pready, s_prdata, s_pslverr,
        input  m_paddr, m_pprot, m_psel, m_penable, m_pwrite, m_pwdata, m_pstrb,
        output m_pready, m_prdata, m_pslverr
    );
endinterface

// File: rtl/apb4_arbiter.sv
// Round-robin arbiter sharing one downstream APB4 segment among
// NUM_MASTERS requesters; every output comes straight from a register.
module apb4_arbiter #(
    parameter  int NUM_MASTERS    = 2,
    parameter  int APB_ADDR_WIDTH = 32,
    parameter  int APB_DATA_WIDTH = 32,
    localparam int IDW            = $clog2(NUM_MASTERS),
    localparam int SW             = APB_DATA_WIDTH / 8
) (
    input  logic           pclk,
    input  logic           presetn,
    apb4_arbiter_if.slave  bus,
    output logic [IDW-1:0] gnt_id,
    output logic           busy
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                    state_q, state_d;
    logic [IDW-1:0]            ptr_q, ptr_d;
    logic [IDW-1:0]            gnt_q, gnt_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [2:0]                pprot_q, pprot_d;
    logic                      pwrite_q, pwrite_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [SW-1:0]             pstrb_q, pstrb_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      busy_q, busy_d;
    logic [NUM_MASTERS-1:0]    pready_q, pready_d;
    logic [NUM_MASTERS-1:0]    pslverr_q, pslverr_d;
    logic [APB_DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic                      found;
    logic [IDW-1:0]            win;
    logic                      unused_penable;

    assign unused_penable = ^bus.s_penable;

    function automatic logic [IDW-1:0] rr_idx(logic [IDW-1:0] p, int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
        return IDW'(s);
    endfunction

    // scan from the far end so the requester closest to ptr wins
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (bus.s_psel[rr_idx(ptr_q, k)]) begin
                found = 1'b1;
                win   = rr_idx(ptr_q, k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        paddr_d   = paddr_q;
        pprot_d   = pprot_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        busy_d    = 1'b0;
        pready_d  = '0;
        pslverr_d = '0;
        prdata_d  = prdata_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = SETUP;
                    gnt_d    = win;
                    paddr_d  = bus.s_paddr[int'(win)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                    pprot_d  = bus.s_pprot[int'(win)*3 +: 3];
                    pwrite_d = bus.s_pwrite[win];
                    pwdata_d = bus.s_pwdata[int'(win)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                    pstrb_d  = bus.s_pwrite[win] ? bus.s_pstrb[int'(win)*SW +: SW] : '0;
                    psel_d   = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
                busy_d    = 1'b1;
            end
            ACCESS: begin
                busy_d = 1'b1;
                if (bus.m_pready) begin
                    state_d          = RESP;
                    prdata_d         = bus.m_prdata;
                    pready_d[gnt_q]  = 1'b1;
                    pslverr_d[gnt_q] = bus.m_pslverr;
                end else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                ptr_d   = (int'(gnt_q) == NUM_MASTERS - 1) ? '0 : gnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            paddr_q   <= '0;
            pprot_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            busy_q    <= 1'b0;
            pready_q  <= '0;
            pslverr_q <= '0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            paddr_q   <= paddr_d;
            pprot_q   <= pprot_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            busy_q    <= busy_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    assign bus.m_paddr   = paddr_q;
    assign bus.m_pprot   = pprot_q;
    assign bus.m_pwrite  = pwrite_q;
    assign bus.m_pwdata  = pwdata_q;
    assign bus.m_pstrb   = pstrb_q;
    assign bus.m_psel    = psel_q;
    assign bus.m_penable = penable_q;
    assign bus.s_pready  = pready_q;
    assign bus.s_pslverr = pslverr_q;
    assign bus.s_prdata  = prdata_q;
    assign gnt_id        = gnt_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_apb4_arbiter.sv
// Self-checking bench for apb4_arbiter: directed scenarios plus a random
// run scored against a transaction-level round-robin model.
module tb_apb4_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic [1:0] gnt_id;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    int          sl_wait = 0;
    logic [31:0] sl_rdata = '0;
    logic        sl_err = 1'b0;
    int          wcnt = 0;

    apb4_arbiter_if #(.NUM_MASTERS(N), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus ();

    apb4_arbiter #(.NUM_MASTERS(N), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) dut (
        .pclk   (pclk),
        .presetn(presetn),
        .bus    (bus),
        .gnt_id (gnt_id),
        .busy   (busy)
    );

    always #5 pclk = ~pclk;

    // downstream slave: sl_wait wait states, garbage on the data lines until ready
    always @(posedge pclk) begin
        #1;
        if (bus.m_psel && bus.m_penable) begin
            bus.m_pready  = (wcnt == sl_wait);
            bus.m_prdata  = (wcnt == sl_wait) ? sl_rdata : $urandom;
            bus.m_pslverr = (wcnt == sl_wait) ? sl_err : 1'($urandom);
            wcnt++;
        end else begin
            bus.m_pready  = 1'b0;
            bus.m_prdata  = $urandom;
            bus.m_pslverr = 1'b0;
            wcnt = 0;
        end
    end

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic sel, input logic wr,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] st, input logic [2:0] pr);
        bus.s_psel[i]              = sel;
        bus.s_pwrite[i]            = wr;
        bus.s_paddr[i*AW +: AW]    = a;
        bus.s_pwdata[i*DW +: DW]   = d;
        bus.s_pstrb[i*SW +: SW]    = st;
        bus.s_pprot[i*3 +: 3]      = pr;
    endtask

    task automatic do_reset;
        presetn = 1'b0;
        tick;
        presetn = 1'b1;
    endtask

    task automatic settle;
        bus.s_psel = '0;
        repeat (3) tick;
    endtask

    task automatic test_reset;
        presetn = 1'b0;
        tick;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (gnt_id !== 2'd0) begin n_bad++; $display("FAIL rst_gnt: got %0d want 0", gnt_id); end
        n_cmp++; if ({bus.m_psel, bus.m_penable, bus.m_pwrite, bus.m_pprot, bus.m_pstrb} !== 10'd0)
            begin n_bad++; $display("FAIL rst_mctl: got %b want 0", {bus.m_psel, bus.m_penable, bus.m_pwrite, bus.m_pprot, bus.m_pstrb}); end
        n_cmp++; if ({bus.m_paddr, bus.m_pwdata} !== 64'd0) begin n_bad++; $display("FAIL rst_mdata: got %h want 0", {bus.m_paddr, bus.m_pwdata}); end
        n_cmp++; if ({bus.s_pready, bus.s_pslverr, bus.s_prdata} !== 38'd0)
            begin n_bad++; $display("FAIL rst_resp: got %h want 0", {bus.s_pready, bus.s_pslverr, bus.s_prdata}); end
        presetn = 1'b1;
    endtask

    task automatic test_write_zero_wait;
        do_reset;
        sl_wait = 0;
        set_req(0, 1'b1, 1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 3'h2);
        tick;
        n_cmp++; if ({bus.m_psel, bus.m_penable} !== 2'b10) begin n_bad++; $display("FAIL wr_setup: got %b want 10", {bus.m_psel, bus.m_penable}); end
        n_cmp++; if (bus.m_paddr !== 32'h1000) begin n_bad++; $display("FAIL wr_addr: got %h want 1000", bus.m_paddr); end
        n_cmp++; if (bus.m_pwdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_data: got %h want deadbeef", bus.m_pwdata); end
        n_cmp++; if ({bus.m_pwrite, bus.m_pstrb, bus.m_pprot} !== 8'b1_1111_010)
            begin n_bad++; $display("FAIL wr_ctl: got %b want 11111010", {bus.m_pwrite, bus.m_pstrb, bus.m_pprot}); end
        n_cmp++; if ({busy, gnt_id} !== 3'b100) begin n_bad++; $display("FAIL wr_gnt: got %b want 100", {busy, gnt_id}); end
        tick;
        n_cmp++; if ({bus.m_psel, bus.m_penable, bus.s_pready} !== 5'b11000)
            begin n_bad++; $display("FAIL wr_access: got %b want 11000", {bus.m_psel, bus.m_penable, bus.s_pready}); end
        tick;
        n_cmp++; if ({bus.s_pready, bus.s_pslverr} !== 6'b001000)
            begin n_bad++; $display("FAIL wr_resp: got %b want 001000", {bus.s_pready, bus.s_pslverr}); end
        n_cmp++; if ({bus.m_psel, bus.m_penable} !== 2'b00) begin n_bad++; $display("FAIL wr_resp_m: got %b want 00", {bus.m_psel, bus.m_penable}); end
        bus.s_psel[0] = 1'b0;
        tick;
        n_cmp++; if ({busy, bus.s_pready} !== 4'b0000) begin n_bad++; $display("FAIL wr_idle: got %b want 0000", {busy, bus.s_pready}); end
    endtask

    task automatic test_read_wait_err;
        logic [2:0] ep;
        sl_wait  = 2;
        sl_rdata = 32'h12345678;
        sl_err   = 1'b1;
        set_req(1, 1'b1, 1'b0, 32'h2004, 32'hA5A5A5A5, 4'hF, 3'h0);
        for (int e = 1; e <= 5; e++) begin
            tick;
            ep = (e == 5) ? 3'b010 : 3'b000;
            n_cmp++; if (bus.s_pready !== ep) begin n_bad++; $display("FAIL rd_pready_e%0d: got %b want %b", e, bus.s_pready, ep); end
            if (e == 1) begin
                n_cmp++; if ({bus.m_pwrite, bus.m_pstrb} !== 5'b0) begin n_bad++; $display("FAIL rd_strb: got %b want 0", {bus.m_pwrite, bus.m_pstrb}); end
                n_cmp++; if ({bus.m_paddr, gnt_id} !== {32'h2004, 2'd1}) begin n_bad++; $display("FAIL rd_addr_gnt: got %h/%0d want 2004/1", bus.m_paddr, gnt_id); end
            end
        end
        n_cmp++; if (bus.s_prdata !== 32'h12345678) begin n_bad++; $display("FAIL rd_data: got %h want 12345678", bus.s_prdata); end
        n_cmp++; if (bus.s_pslverr !== 3'b010) begin n_bad++; $display("FAIL rd_err: got %b want 010", bus.s_pslverr); end
        bus.s_psel[1] = 1'b0;
        sl_err = 1'b0;
        tick;
        n_cmp++; if ({bus.s_pslverr, bus.s_prdata} !== {3'b0, 32'h12345678})
            begin n_bad++; $display("FAIL rd_hold: got %h want 012345678", {bus.s_pslverr, bus.s_prdata}); end
        settle;
    endtask

    task automatic test_round_robin;
        int  k, np;
        int  cnt [N];
        logic done;
        bus.s_psel = '0;
        presetn = 1'b0;
        sl_wait = 0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 32'h100 * (i + 1), 32'h0, 4'h3, 3'h0);
        tick;
        presetn = 1'b1;
        k = 0; np = 0; done = 1'b0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int t = 0; t < 80 && !done; t++) begin
            tick;
            if (bus.m_psel && !bus.m_penable) begin
                n_cmp++; if (int'(gnt_id) != k % N) begin n_bad++; $display("FAIL rr_order_%0d: got %0d want %0d", k, gnt_id, k % N); end
                k++;
            end
            if (bus.s_pready != 3'b0) begin
                for (int i = 0; i < N; i++) cnt[i] += int'(bus.s_pready[i]);
                np++;
                if (np == 2 * N) done = 1'b1;
            end
        end
        n_cmp++; if (!done) begin n_bad++; $display("FAIL rr_timeout: got %0d pulses want %0d", np, 2 * N); end
        for (int i = 0; i < N; i++) begin
            n_cmp++; if (cnt[i] != 2) begin n_bad++; $display("FAIL rr_pulses_%0d: got %0d want 2", i, cnt[i]); end
        end
        settle;
    endtask

    task automatic test_back_to_back;
        int   k, np;
        logic re, done;
        do_reset;
        sl_wait = 0;
        set_req(0, 1'b1, 1'b1, 32'hA0, 32'h1, 4'h1, 3'h0);
        set_req(1, 1'b1, 1'b1, 32'hB0, 32'h2, 4'h1, 3'h0);
        k = 0; np = 0; re = 1'b0; done = 1'b0;
        for (int t = 0; t < 60 && !done; t++) begin
            tick;
            if (bus.m_psel && !bus.m_penable) begin
                n_cmp++; if (int'(gnt_id) != k % 2) begin n_bad++; $display("FAIL alt_order_%0d: got %0d want %0d", k, gnt_id, k % 2); end
                k++;
            end
            if (bus.s_pready[0]) begin
                bus.s_psel[0] = 1'b0;
                re = 1'b1;
            end else if (re) begin
                bus.s_psel[0] = 1'b1;
                re = 1'b0;
            end
            if (bus.s_pready != 3'b0) begin
                np++;
                if (np == 4) done = 1'b1;
            end
        end
        n_cmp++; if (!done || k != 4) begin n_bad++; $display("FAIL alt_count: got %0d grants want 4", k); end
        settle;
    endtask

    task automatic test_reset_in_access;
        logic done;
        do_reset;
        sl_wait = 0;
        set_req(1, 1'b1, 1'b1, 32'h11, 32'h0, 4'h1, 3'h0);
        done = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
            tick;
            if (bus.s_pready[1]) done = 1'b1;
        end
        n_cmp++; if (!done) begin n_bad++; $display("FAIL ra_pre_timeout: got 0 want 1"); end
        settle;
        sl_wait = 1000;
        set_req(0, 1'b1, 1'b1, 32'hA0A0, 32'h0, 4'h1, 3'h0);
        set_req(2, 1'b1, 1'b1, 32'hC2C2, 32'h0, 4'h1, 3'h0);
        done = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
            tick;
            if (bus.m_penable) done = 1'b1;
        end
        n_cmp++; if (!done || gnt_id !== 2'd2) begin n_bad++; $display("FAIL ra_gnt_before: got %0d want 2", gnt_id); end
        presetn = 1'b0;
        tick;
        n_cmp++; if ({busy, gnt_id, bus.m_psel, bus.m_penable, bus.m_pstrb, bus.s_pready, bus.s_pslverr} !== 15'd0)
            begin n_bad++; $display("FAIL ra_outputs: got %b want 0", {busy, gnt_id, bus.m_psel, bus.m_penable, bus.m_pstrb, bus.s_pready, bus.s_pslverr}); end
        n_cmp++; if ({bus.m_paddr, bus.s_prdata} !== 64'd0) begin n_bad++; $display("FAIL ra_data: got %h want 0", {bus.m_paddr, bus.s_prdata}); end
        presetn = 1'b1;
        sl_wait = 0;
        tick;
        n_cmp++; if ({bus.m_psel, bus.m_penable, gnt_id} !== 4'b1000) begin n_bad++; $display("FAIL ra_regrant: got %b want 1000", {bus.m_psel, bus.m_penable, gnt_id}); end
        n_cmp++; if (bus.m_paddr !== 32'hA0A0) begin n_bad++; $display("FAIL ra_regrant_addr: got %h want a0a0", bus.m_paddr); end
        done = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
            tick;
            if (bus.s_pready != 3'b0) begin
                done = 1'b1;
                n_cmp++; if (bus.s_pready !== 3'b001) begin n_bad++; $display("FAIL ra_pulse: got %b want 001", bus.s_pready); end
            end
        end
        n_cmp++; if (!done) begin n_bad++; $display("FAIL ra_timeout: got 0 want 1"); end
        settle;
    endtask

    task automatic test_drop_psel;
        do_reset;
        sl_wait = 0;
        set_req(0, 1'b1, 1'b1, 32'h40, 32'h7, 4'h1, 3'h0);
        tick;
        n_cmp++; if ({bus.m_psel, bus.m_penable, gnt_id} !== 4'b1000) begin n_bad++; $display("FAIL dp_setup: got %b want 1000", {bus.m_psel, bus.m_penable, gnt_id}); end
        bus.s_psel[0] = 1'b0;
        tick;
        n_cmp++; if ({bus.m_psel, bus.m_penable} !== 2'b11) begin n_bad++; $display("FAIL dp_access: got %b want 11", {bus.m_psel, bus.m_penable}); end
        tick;
        n_cmp++; if (bus.s_pready !== 3'b001) begin n_bad++; $display("FAIL dp_pulse: got %b want 001", bus.s_pready); end
        tick;
        n_cmp++; if ({busy, bus.s_pready} !== 4'b0) begin n_bad++; $display("FAIL dp_idle: got %b want 0", {busy, bus.s_pready}); end
        set_req(0, 1'b1, 1'b1, 32'h40, 32'h7, 4'h1, 3'h0);
        set_req(1, 1'b1, 1'b1, 32'h44, 32'h8, 4'h1, 3'h0);
        tick;
        n_cmp++; if ({bus.m_psel, gnt_id} !== 3'b101) begin n_bad++; $display("FAIL dp_ptr: got %b want 101", {bus.m_psel, gnt_id}); end
        settle;
        settle;
    endtask

    task automatic test_random;
        logic [31:0] ra [N];
        logic [31:0] rd [N];
        logic        rw [N];
        logic [3:0]  rs [N];
        logic [2:0]  rp [N];
        logic        pend [N];
        int          waits [N];
        int          mptr, win, resp_cyc, w;
        logic        in_x, idle_prev, any_prev, start, resp_now;
        logic [31:0] e_rd;
        logic        e_err;
        logic [2:0]  ep;
        do_reset;
        bus.s_psel = '0;
        for (int i = 0; i < N; i++) begin pend[i] = 1'b0; waits[i] = 0; end
        mptr = 0; win = 0; resp_cyc = -1; in_x = 1'b0;
        idle_prev = 1'b1; any_prev = 1'b0; e_rd = '0; e_err = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            tick;
            resp_now = in_x && (cyc == resp_cyc);
            start    = idle_prev && any_prev;
            n_cmp++; if ((bus.m_psel && !bus.m_penable) !== start)
                begin n_bad++; $display("FAIL rnd_start c%0d: got %b want %b", cyc, bus.m_psel && !bus.m_penable, start); end
            ep = '0;
            if (resp_now) ep[win] = 1'b1;
            n_cmp++; if (bus.s_pready !== ep) begin n_bad++; $display("FAIL rnd_pready c%0d: got %b want %b", cyc, bus.s_pready, ep); end
            if (resp_now) begin
                n_cmp++; if (bus.s_pslverr !== (e_err ? ep : 3'b0)) begin n_bad++; $display("FAIL rnd_err c%0d: got %b want %b", cyc, bus.s_pslverr, e_err ? ep : 3'b0); end
                n_cmp++; if (bus.s_prdata !== e_rd) begin n_bad++; $display("FAIL rnd_rdata c%0d: got %h want %h", cyc, bus.s_prdata, e_rd); end
                in_x = 1'b0;
                mptr = (win + 1) % N;
                pend[win] = 1'b0;
                bus.s_psel[win] = 1'b0;
            end else begin
                n_cmp++; if (bus.s_pslverr !== 3'b0) begin n_bad++; $display("FAIL rnd_err_idle c%0d: got %b want 000", cyc, bus.s_pslverr); end
            end
            if (start) begin
                win = -1;
                for (int k = N - 1; k >= 0; k--) if (pend[(mptr + k) % N]) win = (mptr + k) % N;
                n_cmp++; if (int'(gnt_id) != win) begin n_bad++; $display("FAIL rnd_gnt c%0d: got %0d want %0d", cyc, gnt_id, win); end
                if (win < 0) win = 0;
                n_cmp++; if ({bus.m_paddr, bus.m_pwdata, bus.m_pwrite, bus.m_pprot} !== {ra[win], rd[win], rw[win], rp[win]})
                    begin n_bad++; $display("FAIL rnd_fields c%0d: got %h %h want %h %h", cyc, bus.m_paddr, bus.m_pwdata, ra[win], rd[win]); end
                n_cmp++; if (bus.m_pstrb !== (rw[win] ? rs[win] : 4'h0)) begin n_bad++; $display("FAIL rnd_strb c%0d: got %h want %h", cyc, bus.m_pstrb, rw[win] ? rs[win] : 4'h0); end
                for (int j = 0; j < N; j++) begin
                    if (j != win && pend[j]) begin
                        waits[j]++;
                        n_cmp++; if (waits[j] > N - 1) begin n_bad++; $display("FAIL rnd_fair c%0d: got %0d waits want <=%0d", cyc, waits[j], N - 1); end
                    end
                end
                w = $urandom_range(0, 3);
                sl_wait  = w;
                e_rd     = $urandom;
                e_err    = 1'($urandom);
                sl_rdata = e_rd;
                sl_err   = e_err;
                resp_cyc = cyc + 2 + w;
                in_x = 1'b1;
            end
            n_cmp++; if (busy !== (in_x || resp_now)) begin n_bad++; $display("FAIL rnd_busy c%0d: got %b want %b", cyc, busy, in_x || resp_now); end
            idle_prev = !(in_x || resp_now);
            if (cyc < 1800) begin
                for (int i = 0; i < N; i++) begin
                    if (!pend[i] && $urandom_range(0, 2) == 0) begin
                        pend[i] = 1'b1; waits[i] = 0;
                        ra[i] = $urandom; rd[i] = $urandom; rw[i] = 1'($urandom);
                        rs[i] = 4'($urandom); rp[i] = 3'($urandom);
                        set_req(i, 1'b1, rw[i], ra[i], rd[i], rs[i], rp[i]);
                    end
                end
            end
            any_prev = pend[0] || pend[1] || pend[2];
        end
        n_cmp++; if (any_prev) begin n_bad++; $display("FAIL rnd_drain: got pending want none"); end
        settle;
    endtask

    initial begin
        bus.s_psel    = '0;
        bus.s_penable = '0;
        bus.s_pwrite  = '0;
        bus.s_paddr   = '0;
        bus.s_pwdata  = '0;
        bus.s_pstrb   = '0;
        bus.s_pprot   = '0;
        test_reset;
        test_write_zero_wait;
        test_read_wait_err;
        test_round_robin;
        test_back_to_back;
        test_reset_in_access;
        test_drop_psel;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/apb4_arbiter.md
# apb4_arbiter

Round-robin arbiter that lets `NUM_MASTERS` APB4 requesters share one downstream APB4 slave bus. Each requester port is a flattened APB4 slave-side bundle; the single downstream port is an APB4 master-side bundle. The block registers the winning request, runs a full SETUP/ACCESS sequence on the downstream bus, then returns the captured response to the winner. It sits between CPU/DMA-style APB initiators and a shared peripheral APB segment.

## Interface
- `NUM_MASTERS`, 2, number of requesters (≥2); `IDW = $clog2(NUM_MASTERS)`
- `APB_ADDR_WIDTH`, 32, address width
- `APB_DATA_WIDTH`, 32, data width (multiple of 8); `SW = APB_DATA_WIDTH/8`
- `pclk  in  1  clock`
- `presetn  in  1  reset; one clock; reset is synchronous and active-low`
- `s_paddr  in  NUM_MASTERS*APB_ADDR_WIDTH  requester addresses, slice i = requester i`
- `s_pprot  in  NUM_MASTERS*3  requester protection`
- `s_psel  in  NUM_MASTERS  requester select (request)`
- `s_penable  in  NUM_MASTERS  requester enable (unused for arbitration)`
- `s_pwrite  in  NUM_MASTERS  requester direction`
- `s_pwdata  in  NUM_MASTERS*APB_DATA_WIDTH  requester write data`
- `s_pstrb  in  NUM_MASTERS*SW  requester write strobes`
- `s_pready  out  NUM_MASTERS  per-requester completion`
- `s_prdata  out  APB_DATA_WIDTH  captured read data, shared by all requesters`
- `s_pslverr  out  NUM_MASTERS  per-requester error, valid with s_pready`
- `m_paddr, m_pprot, m_psel, m_penable, m_pwrite, m_pwdata, m_pstrb  out  (APB widths)  downstream request`
- `m_pready, m_prdata, m_pslverr  in  (APB widths)  downstream response`
- `gnt_id  out  IDW  index of current/last granted requester`
- `busy  out  1  high in SETUP, ACCESS, RESP`

## Operation
- FSM states IDLE, SETUP, ACCESS, RESP; all outputs registered.
- IDLE: if any `s_psel` high, pick winner = first i with `s_psel[i]` scanning ptr, ptr+1, … wrapping mod NUM_MASTERS. Capture winner's paddr/pprot/pwrite/pwdata/pstrb into downstream registers; `m_pstrb` forced to 0 when captured pwrite=0. `gnt_id`←winner. Go SETUP.
- SETUP: `m_psel=1`, `m_penable=0`. Unconditionally go ACCESS.
- ACCESS: `m_psel=1`, `m_penable=1`, request fields held stable. On `m_pready=1`: capture `m_prdata`→`s_prdata`, `m_pslverr`→`s_pslverr[gnt_id]`, go RESP. Otherwise stay (unbounded wait states).
- RESP: `m_psel=m_penable=0`; `s_pready[gnt_id]=1` for exactly one cycle; ptr←(gnt_id+1) mod NUM_MASTERS. Go IDLE.
- `s_pready`/`s_pslverr` bits of non-granted requesters always 0. `s_pslverr` only nonzero in RESP. `s_prdata` holds last captured value until next capture.
- Requests arriving while busy wait; no transfer is ever dropped or merged.
- Requester dropping `s_psel` mid-transfer (protocol violation): downstream transfer still completes; RESP pulse still issued.

## Timing
- Reset (presetn=0 at a clock edge): state IDLE, ptr=0, gnt_id=0, busy=0, all `m_*` outputs 0, `s_pready`=0, `s_pslverr`=0, `s_prdata`=0. Reset in SETUP/ACCESS aborts the downstream transfer with no response.
- Requester psel seen high at edge E0 (IDLE): SETUP cycle after E0, ACCESS after E1, RESP after edge where m_pready sampled high. Zero-wait slave: `s_pready` high in 4th cycle counting psel cycle as 1st (3 edges after psel).
- Each additional downstream wait state adds one cycle.
- Back-to-back: IDLE occupies ≥1 cycle between transfers; minimum period 4 cycles per transfer.
- Simultaneous requests in IDLE: round-robin from ptr; ptr updates only in RESP.
- NUM_MASTERS not a power of two: ptr wraps from NUM_MASTERS-1 to 0.

## Test plan
- Requester 0 writes addr 0x1000 data 0xDEADBEEF strb 0xF, zero-wait slave -> one downstream SETUP then ACCESS with those values, `s_pready[0]` pulses 3 edges after psel, `s_pslverr[0]`=0, gnt_id=0.
- Requester 1 reads 0x2004, slave inserts 2 wait states returning 0x12345678, pslverr=1 -> `m_pstrb`=0, `s_prdata`=0x12345678 and `s_pslverr[1]`=1 in RESP, 5 edges after psel.
- NUM_MASTERS=3, all three assert psel continuously from reset -> grant order 0,1,2,0,1,2; each requester gets exactly one pready pulse per round.
- Requester 0 re-requests immediately after each completion while requester 1 is pending -> grants alternate 0,1,0,1; no requester waits more than NUM_MASTERS-1 transfers.
- presetn low for one cycle during ACCESS with m_pready=0 -> next cycle all outputs 0, state IDLE, no s_pready pulse; pending request then re-granted starting from requester 0.
- Requester 0 drops psel in SETUP -> downstream transfer completes, s_pready[0] pulse still occurs, then arbiter returns to IDLE and ptr=1.
